// File: rtl/arb_32_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// arb_32_ctrl_pkg
// Shared definitions for the 32-requester arbiter:
//   NUM_REQ  - number of requesters (32)
//   IDX_W    - width of a requester index (5)
//   state_t  - arbiter FSM encoding (IDLE=0, BUSY=1)
//   id_dec   - index decrement with wrap 0 -> 31 (round-robin pointer update)
// ---------------------------------------------------------------------------
package arb_32_ctrl_pkg;

    localparam int NUM_REQ = 32;
    localparam int IDX_W   = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Modulo-32 decrement: the natural wrap of a 5-bit subtraction.
    function automatic logic [IDX_W-1:0] id_dec(input logic [IDX_W-1:0] id);
        return id - {{(IDX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/arb_32_ctrl_pri_enc.sv
// ---------------------------------------------------------------------------
// pri_enc_32_5
// Combinational 32-to-5 priority encoder; the highest set bit wins.
// Ports:
//   vec [31:0] in  - input vector
//   idx [4:0]  out - index of the highest set bit (0 when vec is zero)
//   vld        out - vec has at least one bit set
// ---------------------------------------------------------------------------
module pri_enc_32_5
    import arb_32_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    always_comb begin
        idx = '0;
        // Ascending scan: the last hit, i.e. the highest index, is kept.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        vld = |vec;
    end

endmodule

// File: rtl/arb_32_ctrl.sv
// ---------------------------------------------------------------------------
// arb_32_ctrl
// 32-requester arbiter with a bounded hold time. A grant is held while the
// winner keeps its request high, for at most MAX_HOLD cycles. When the limit
// is reached the grant is revoked with a one-cycle timeout pulse, and the
// revoked requester sits out the next arbitration.
//
// Parameter:
//   MAX_HOLD (2..255, default 16) - maximum cycles a grant stays asserted
// Ports:
//   clk           in  - clock, rising edge
//   rst           in  - synchronous active-high reset
//   en            in  - arbitration enable (a running grant is not affected)
//   req [31:0]    in  - request vector
//   gnt [31:0]    out - one-hot grant, registered
//   gnt_id [4:0]  out - index of the granted requester, 0 when idle
//   gnt_vld       out - a grant is held
//   timeout       out - one-cycle pulse when a grant is revoked by MAX_HOLD
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - round-robin selection with a pointer register.
//                        If it is undefined, the highest-index request wins.
// ---------------------------------------------------------------------------
module arb_32_ctrl
    import arb_32_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_vld,
    output logic               timeout
);

    localparam logic [7:0]       HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] ONE_ID    = IDX_W'(1);

    state_t               state_reg,    state_next;
    logic [NUM_REQ-1:0]   gnt_reg,      gnt_next;
    logic [IDX_W-1:0]     gnt_id_reg,   gnt_id_next;
    logic                 gnt_vld_reg,  gnt_vld_next;
    logic                 timeout_reg,  timeout_next;
    logic [7:0]           hold_cnt_reg, hold_cnt_next;
    logic [NUM_REQ-1:0]   mask_reg,     mask_next;

    logic [NUM_REQ-1:0]   req_masked;
    logic [NUM_REQ-1:0]   enc_in;
    logic [IDX_W-1:0]     enc_idx;
    logic                 enc_vld;
    logic [IDX_W-1:0]     win_id;
    logic [NUM_REQ-1:0]   win_onehot;

    // A requester revoked by the hold limit is excluded for one arbitration.
    assign req_masked = req & ~mask_reg;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_reg, ptr_next;

    // Rotate so that requester ptr lands on bit 31: bit gi of the encoder
    // input is requester (gi + ptr + 1) mod 32. The highest set bit is then
    // the first request found scanning downward from ptr with wrap-around.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign enc_in[gi] = req_masked[IDX_W'(gi) + ptr_reg + ONE_ID];
        end
    endgenerate

    // Undo the rotation; the 5-bit sum wraps modulo 32.
    assign win_id = enc_idx + ptr_reg + ONE_ID;
`else
    assign enc_in = req_masked;
    assign win_id = enc_idx;
`endif

    pri_enc_32_5 u_pri_enc (
        .vec (enc_in),
        .idx (enc_idx),
        .vld (enc_vld)
    );

    genvar di;
    generate
        for (di = 0; di < NUM_REQ; di++) begin : g_dec
            assign win_onehot[di] = (win_id == IDX_W'(di));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_id_next   = gnt_id_reg;
        gnt_vld_next  = gnt_vld_reg;
        timeout_next  = 1'b0;
        hold_cnt_next = hold_cnt_reg;
        mask_next     = mask_reg;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_next      = ptr_reg;
`endif

        unique case (state_reg)
            IDLE: begin
                gnt_next      = '0;
                gnt_id_next   = '0;
                gnt_vld_next  = 1'b0;
                hold_cnt_next = '0;
                // The mask only lives through this one IDLE cycle.
                mask_next     = '0;
                if (en && enc_vld) begin
                    state_next   = BUSY;
                    gnt_next     = win_onehot;
                    gnt_id_next  = win_id;
                    gnt_vld_next = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_next     = id_dec(win_id);
`endif
                end
            end

            BUSY: begin
                hold_cnt_next = hold_cnt_reg + 8'd1;
                // Release is checked first, so a drop on the last allowed
                // cycle ends the grant normally without a timeout.
                if (!req[gnt_id_reg]) begin
                    state_next    = IDLE;
                    gnt_next      = '0;
                    gnt_id_next   = '0;
                    gnt_vld_next  = 1'b0;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next    = IDLE;
                    gnt_next      = '0;
                    gnt_id_next   = '0;
                    gnt_vld_next  = 1'b0;
                    hold_cnt_next = '0;
                    timeout_next  = 1'b1;
                    mask_next     = gnt_reg;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            gnt_vld_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            hold_cnt_reg <= '0;
            mask_reg     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_reg      <= '1;
`endif
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_id_reg   <= gnt_id_next;
            gnt_vld_reg  <= gnt_vld_next;
            timeout_reg  <= timeout_next;
            hold_cnt_reg <= hold_cnt_next;
            mask_reg     <= mask_next;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_reg      <= ptr_next;
`endif
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign gnt_vld = gnt_vld_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_arb_32_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arb_32_ctrl
// Directed bench for arb_32_ctrl (MAX_HOLD = 16). Inputs are driven 1 ns
// after a rising edge and outputs are sampled 1 ns after the following edge.
// With ARB_ROUND_ROBIN_EN defined, the rotation test expects a descending
// pointer sequence. Otherwise it expects fixed priority.
// ---------------------------------------------------------------------------
module tb_arb_32_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] req;
    logic [31:0] gnt;
    logic [4:0]  gnt_id;
    logic        gnt_vld;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    arb_32_ctrl #(.MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; req = '0;
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt, timeout} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: vld=%b id=%0d gnt=%h to=%b, want all 0", gnt_vld, gnt_id, gnt, timeout);
        end
        rst = 1'b0;
        tick();
        $display("reset: vld=%b id=%0d gnt=%h", gnt_vld, gnt_id, gnt);
    endtask

    task automatic test_single;
        en = 1'b1; req = 32'h0000_0001;
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt} !== {1'b1, 5'd0, 32'h0000_0001}) begin
            errors++;
            $display("FAIL single_grant: vld=%b id=%0d gnt=%h, want 1/0/00000001", gnt_vld, gnt_id, gnt);
        end
        req = '0;
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt, timeout} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL single_release: vld=%b id=%0d gnt=%h to=%b, want all 0", gnt_vld, gnt_id, gnt, timeout);
        end
        tick();
        $display("single: grant id 0 then release");
    endtask

    task automatic test_priority;
        req = 32'h8000_0005;
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt} !== {1'b1, 5'd31, 32'h8000_0000}) begin
            errors++;
            $display("FAIL prio_first: vld=%b id=%0d gnt=%h, want 1/31/80000000", gnt_vld, gnt_id, gnt);
        end
        // Other requesters change during the grant; the grant must not move.
        req = 32'h8000_0004;
        tick();
        req = 32'h8000_00F4;
        tick();
        checks++;
        if ({gnt_vld, gnt_id} !== {1'b1, 5'd31}) begin
            errors++;
            $display("FAIL prio_hold: vld=%b id=%0d, want 1/31", gnt_vld, gnt_id);
        end
        req = 32'h0000_0004;
        tick();
        checks++;
        if ({gnt_vld, gnt} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL prio_idle: vld=%b gnt=%h, want 0/0", gnt_vld, gnt);
        end
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt} !== {1'b1, 5'd2, 32'h0000_0004}) begin
            errors++;
            $display("FAIL prio_second: vld=%b id=%0d gnt=%h, want 1/2/00000004", gnt_vld, gnt_id, gnt);
        end
        req = '0;
        tick();
        tick();
        $display("priority: 31 then 2");
    endtask

    task automatic test_timeout;
        int held;
        req = 32'h0000_0088;
        tick();
        held = (gnt_vld && gnt_id == 5'd7) ? 1 : 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (gnt_vld && gnt_id == 5'd7 && !timeout) held++;
        end
        checks++;
        if (held !== 16) begin
            errors++;
            $display("FAIL timeout_hold_cycles: got %0d, want 16", held);
        end
        tick();
        checks++;
        if ({gnt_vld, gnt, timeout} !== {1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_pulse: vld=%b gnt=%h to=%b, want 0/0/1", gnt_vld, gnt, timeout);
        end
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt, timeout} !== {1'b1, 5'd3, 32'h0000_0008, 1'b0}) begin
            errors++;
            $display("FAIL timeout_mask: vld=%b id=%0d gnt=%h to=%b, want 1/3/00000008/0", gnt_vld, gnt_id, gnt, timeout);
        end
        req = '0;
        tick();
        tick();
        $display("timeout: 7 held %0d cycles, then 3", held);
    endtask

    task automatic test_release_at_limit;
        req = 32'h0000_0010;
        tick();
        for (int k = 0; k < 15; k++) tick();
        checks++;
        if ({gnt_vld, gnt_id} !== {1'b1, 5'd4}) begin
            errors++;
            $display("FAIL limit_still_held: vld=%b id=%0d, want 1/4", gnt_vld, gnt_id);
        end
        // The drop coincides with the hold limit: a plain release.
        req = '0;
        tick();
        checks++;
        if ({gnt_vld, gnt, timeout} !== {1'b0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL limit_release: vld=%b gnt=%h to=%b, want 0/0/0", gnt_vld, gnt, timeout);
        end
        tick();
        $display("release at limit: no timeout");
    endtask

    task automatic test_rst_busy;
        req = 32'h0000_0020;
        tick();
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt, timeout} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_busy: vld=%b id=%0d gnt=%h to=%b, want all 0", gnt_vld, gnt_id, gnt, timeout);
        end
        rst = 1'b0; req = '0;
        tick();
        $display("reset during grant cycle 5: outputs cleared");
    endtask

    task automatic test_enable;
        en = 1'b0; req = 32'h0000_0100;
        tick();
        tick();
        checks++;
        if ({gnt_vld, gnt} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL en_low: vld=%b gnt=%h, want 0/0", gnt_vld, gnt);
        end
        en = 1'b1;
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt} !== {1'b1, 5'd8, 32'h0000_0100}) begin
            errors++;
            $display("FAIL en_rise: vld=%b id=%0d gnt=%h, want 1/8/00000100", gnt_vld, gnt_id, gnt);
        end
        // Dropping en does not cut a running grant.
        en = 1'b0;
        tick();
        checks++;
        if ({gnt_vld, gnt_id} !== {1'b1, 5'd8}) begin
            errors++;
            $display("FAIL en_drop_busy: vld=%b id=%0d, want 1/8", gnt_vld, gnt_id);
        end
        req = '0;
        tick();
        tick();
        en = 1'b1;
        $display("enable: id 8 after en rises");
    endtask

    task automatic test_back_to_back;
        req = 32'h0000_0002;
        tick();
        req = '0;
        tick();
        checks++;
        if (gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: vld=%b, want 0", gnt_vld);
        end
        req = 32'h0000_0002;
        tick();
        checks++;
        if ({gnt_vld, gnt_id, gnt} !== {1'b1, 5'd1, 32'h0000_0002}) begin
            errors++;
            $display("FAIL b2b_regrant: vld=%b id=%0d gnt=%h, want 1/1/00000002", gnt_vld, gnt_id, gnt);
        end
        req = '0;
        tick();
        tick();
        $display("back-to-back: 2-cycle spacing");
    endtask

    task automatic test_round_robin;
        logic [4:0] exp_id;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k <= 32; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_id = 5'(31 - k);
`else
            exp_id = 5'd31;
`endif
            req = 32'hFFFF_FFFF;
            tick();
            checks++;
            if ({gnt_vld, gnt_id, gnt} !== {1'b1, exp_id, (32'd1 << exp_id)}) begin
                errors++;
                $display("FAIL rr_step%0d: vld=%b id=%0d gnt=%h, want id %0d", k, gnt_vld, gnt_id, gnt, exp_id);
            end
            req = '0;
            tick();
        end
        tick();
        $display("rotation: 33 grants, final id %0d", exp_id);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = '0;
        test_reset();
        test_single();
        test_priority();
        test_timeout();
        test_release_at_limit();
        test_rst_busy();
        test_enable();
        test_back_to_back();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arb_32_ctrl.md
ARB_32_CTRL -- requirements
Module: arb_32_ctrl

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, legal range 2..255: maximum number of cycles one grant stays asserted.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port en  input  1  arbitration enable; when low, no new grant is issued, but an existing grant runs to completion.
REQ-005 SHALL have port req  input  32  request vector, bit i = requester i; requester holds bit high while it wants or uses the resource.
REQ-006 SHALL have port gnt  output  32  one-hot grant vector, registered.
REQ-007 SHALL have port gnt_id  output  5  binary index of the granted requester, registered; 0 when gnt_vld=0.
REQ-008 SHALL have port gnt_vld  output  1  high while any grant is held, registered.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-010 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-011 IDLE: when en=1 and the masked request vector is non-zero at a rising edge, the block SHALL register the winner into gnt/gnt_id, set gnt_vld=1, clear hold_cnt, and enter BUSY; grant latency is exactly one cycle from the sampled request.
REQ-012 IDLE with en=0 or masked request vector zero SHALL remain in IDLE with all outputs 0.
REQ-013 Fixed-priority winner (macro absent) SHALL be the highest-index asserted bit; req=0 never produces a grant.
REQ-014 BUSY: hold_cnt SHALL increment by 1 each cycle, saturating logic not required because of REQ-016.
REQ-015 BUSY with req[gnt_id]=0 sampled SHALL release: the next cycle shows gnt=0, gnt_vld=0, gnt_id=0, state IDLE; timeout stays 0.
REQ-016 BUSY with req[gnt_id]=1 and hold_cnt=MAX_HOLD-1 SHALL revoke: the next cycle shows gnt=0, gnt_vld=0, timeout=1 for exactly one cycle, state IDLE.
REQ-017 A revoked requester SHALL be masked out of the single arbitration that follows the revocation; the mask clears after that arbitration or after one IDLE cycle with no grant.
REQ-018 Release and revocation in the same cycle SHALL be treated as release (timeout=0).
REQ-019 Any grant SHALL be followed by at least one IDLE cycle; back-to-back grants are spaced MAX_HOLD+1 cycles at most and 2 cycles at least.
REQ-020 Changes on req bits other than gnt_id SHALL NOT affect an active grant.
REQ-021 gnt SHALL always equal (1 << gnt_id) when gnt_vld=1 and 0 otherwise.

Reset
REQ-022 rst=1 at a rising edge SHALL force state IDLE and gnt=0, gnt_id=0, gnt_vld=0, timeout=0, hold_cnt=0, revoke mask=0, and round-robin pointer=31, including mid-grant.
REQ-023 rst SHALL take precedence over all other inputs.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first asserted bit scanning downward from pointer ptr, wrapping 0 to 31; after each grant ptr = (gnt_id-1) mod 32.
REQ-025 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-013, and no pointer register is instantiated.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=0, BUSY=1), the requester count 32, and the index width 5.
REQ-027 Winner selection SHALL use one sub-module pri_enc_32_5 (combinational 32-to-5 highest-bit priority encoder with valid output); round-robin SHALL rotate the vector before it and add ptr after it.

Verification
REQ-028 The bench SHALL cover: req=0x0000_0001, en=1 -> next cycle gnt=0x0000_0001, gnt_id=0, gnt_vld=1.
REQ-029 The bench SHALL cover: req=0x8000_0005 held, fixed priority -> gnt_id=31; after its drop, gnt_id=2 after one IDLE cycle.
REQ-030 The bench SHALL cover: req[7] held 40 cycles, MAX_HOLD=16 -> gnt for 16 cycles, timeout pulse, and req[3] (also high) granted next, not 7.
REQ-031 The bench SHALL cover: rst asserted during BUSY at cycle 5 of grant -> all outputs 0 the next cycle.
REQ-032 The bench SHALL cover: ARB_ROUND_ROBIN_EN, req=0xFFFF_FFFF held with 1-cycle drops -> gnt_id sequence 31,30,29,...,0,31.
REQ-033 The bench SHALL cover: en=0 with req=0x0000_0100 -> no grant; en rises -> gnt_id=8 one cycle later.
